ahb_slave_if: RTL and testbench
===============================

// Module: ahb_slave_if
// PURPOSE
//  AHB-Lite slave interface. It consumes the address/control/data bus driven by ahb_master_if and turns each
//  accepted transfer into one request/acknowledge access on a simple backend register/memory port.
//  It produces HREADYOUT, HRESP and HRDATA with wait states and the two-cycle ERROR response.
//  Widths are configurable.
// PARAMETERS
//  AHB_ADDR_WIDTH    32  address bus width
//  AHB_DATA_WIDTH    32  data bus width (32 or 64); strobe width is AHB_DATA_WIDTH/8
//  SLV_WAIT_TIMEOUT  15  max backend wait cycles in ACCESS before an ERROR response (>=1)
// PORTS
//  ahb_clk_in        in   1                 bus clock; all logic on posedge
//  ahb_rst_in        in   1                 asynchronous, active-high reset
//  ahb_sel_in        in   1                 HSEL for this slave
//  ahb_addr_in       in   AHB_ADDR_WIDTH    HADDR
//  ahb_trans_in      in   2                 HTRANS: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//  ahb_burst_in      in   3                 HBURST; informational only, every beat is addressed explicitly
//  ahb_size_in       in   3                 HSIZE; bytes = 1<<size
//  ahb_write_in      in   1                 HWRITE
//  ahb_wdata_in      in   AHB_DATA_WIDTH    HWDATA, valid during the data phase
//  ahb_ready_in      in   1                 global HREADY (bus-level)
//  ahb_readyout_out  out  1                 HREADYOUT of this slave
//  ahb_resp_out      out  1                 HRESP: 0 OKAY, 1 ERROR
//  ahb_rdata_out     out  AHB_DATA_WIDTH    HRDATA
//  slv_req_out       out  1                 backend request; held until ack
//  slv_write_out     out  1                 backend write (1) / read (0)
//  slv_addr_out      out  AHB_ADDR_WIDTH    latched transfer address
//  slv_strb_out      out  AHB_DATA_WIDTH/8  byte-lane strobes
//  slv_wdata_out     out  AHB_DATA_WIDTH    write data, passed through from ahb_wdata_in
//  slv_ack_in        in   1                 backend done; sampled only while slv_req_out=1
//  slv_err_in        in   1                 backend error, qualified by slv_ack_in
//  slv_rdata_in      in   AHB_DATA_WIDTH    backend read data, qualified by slv_ack_in
// BEHAVIOUR
//  Reset (async, immediate): state IDLE. ahb_readyout_out=1, ahb_resp_out=0, ahb_rdata_out=0.
//   slv_req_out=0, slv_write_out=0, slv_addr_out=0, slv_strb_out=0. Timeout counter=0.
//  Reset asserted mid-transfer drops slv_req_out at once; the backend must discard the pending access.
//  Address phase is sampled on a posedge when ahb_sel_in & ahb_ready_in & ahb_trans_in[1] (NONSEQ/SEQ).
//   A valid sample latches addr, write, size and computes the strobes into slv_*_out.
//   IDLE or BUSY transfers, or no sel, get a zero-wait OKAY: readyout=1, resp=0. No backend access.
//   With ahb_ready_in=0 nothing is sampled; another slave owns the data phase.
//  Invalid transfer, which goes to ERR1 with no backend request:
//   (8<<size) > AHB_DATA_WIDTH, or addr not aligned to 1<<size.
//  Strobes: ((1<<(1<<size))-1) << (addr mod (AHB_DATA_WIDTH/8)). Example, 32-bit bus:
//   size 0 addr 0x3 -> 4'b1000; size 1 addr 0x2 -> 4'b1100; size 2 -> 4'b1111.
//  FSM states: IDLE, ACCESS, DONE, ERR1, ERR2.
//   IDLE   : valid sample -> ACCESS; invalid sample -> ERR1; otherwise stay.
//   ACCESS : slv_req_out=1, readyout=0, resp=0; counter increments each cycle.
//            ack & !err -> DONE (for a read, ahb_rdata_out<=slv_rdata_in).
//            ack & err  -> ERR1.
//            no ack and counter==SLV_WAIT_TIMEOUT-1 -> ERR1.
//            On every exit: slv_req_out<=0 and counter<=0.
//   DONE   : readyout=1, resp=0; one cycle. A new address phase can be sampled on the same edge,
//            with the same branching as IDLE; otherwise -> IDLE.
//   ERR1   : readyout=0, resp=1 -> ERR2.
//   ERR2   : readyout=1, resp=1; address phase sampled as in IDLE. The master may issue IDLE to cancel.
//  Latency: data phase = (cycles to ack) + 1. Minimum 2 cycles with ack in the first ACCESS cycle.
//   An error always takes 2 cycles (ERR1, ERR2).
//  slv_wdata_out = ahb_wdata_in combinationally; it is stable because readyout=0 stalls the master.
//  ahb_rdata_out updates only on a read ack, is cleared to 0 on a write ack, and otherwise holds its value.
//  slv_ack_in while slv_req_out=0 is ignored.
//  BUSY inside a burst is accepted with OKAY and no access, and does not disturb the DONE/IDLE flow.
// TESTING
//  1 Reset pulse during ACCESS -> slv_req_out falls in the same cycle; readyout=1, resp=0, rdata=0.
//  2 NONSEQ write, addr 0x10, size 2, wdata 0xA5A55A5A, ack 2 cycles after req
//    -> req high 2 cycles, strb=4'hF, slv_wdata=0xA5A55A5A; readyout low 2 cycles then 1, resp 0.
//  3 NONSEQ read, addr 0x4, size 1, ack in the first cycle with rdata 0x12345678
//    -> strb=4'b0011; data phase 2 cycles; ahb_rdata_out=0x12345678 while readyout=1.
//  4 Invalid transfers (size 2 addr 0x2; size 3 on a 32-bit bus)
//    -> readyout 0/1 with resp 1/1 over 2 cycles; slv_req_out never asserted.
//  5 SLV_WAIT_TIMEOUT=4 and ack never arrives -> req high exactly 4 cycles, then a 2-cycle ERROR.
//    Ack with slv_err_in=1 -> 2-cycle ERROR.
//  6 INCR4 write at 0x20 with one BUSY after beat 2 -> backend addrs 0x20,0x24,0x28,0x2C in order,
//    BUSY gets a zero-wait OKAY, and all beats end with resp 0.

Source files
------------

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave interface.
// Turns each accepted AHB-Lite transfer into a single request/acknowledge access on a simple
// backend port, generating HREADYOUT wait states, the two-cycle ERROR response and HRDATA.
//
// Ports
//   ahb_clk_in, ahb_rst_in      : bus clock (posedge), asynchronous active-high reset
//   ahb_sel_in .. ahb_ready_in  : AHB-Lite address/control/data inputs (HSEL, HADDR, HTRANS,
//                                 HBURST, HSIZE, HWRITE, HWDATA, HREADY)
//   ahb_readyout_out            : HREADYOUT of this slave
//   ahb_resp_out                : HRESP (0 OKAY, 1 ERROR)
//   ahb_rdata_out               : HRDATA, loaded on a read acknowledge
//   slv_req_out .. slv_wdata_out: backend request, direction, address, byte strobes, write data
//   slv_ack_in, slv_err_in      : backend completion and error (error qualified by ack)
//   slv_rdata_in                : backend read data (qualified by ack)
module ahb_slave_if #(
  parameter int unsigned AHB_ADDR_WIDTH   = 32,
  parameter int unsigned AHB_DATA_WIDTH   = 32,
  parameter int unsigned SLV_WAIT_TIMEOUT = 15
) (
  input  logic                          ahb_clk_in,
  input  logic                          ahb_rst_in,
  input  logic                          ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0]     ahb_addr_in,
  input  logic [1:0]                    ahb_trans_in,
  input  logic [2:0]                    ahb_burst_in,
  input  logic [2:0]                    ahb_size_in,
  input  logic                          ahb_write_in,
  input  logic [AHB_DATA_WIDTH-1:0]     ahb_wdata_in,
  input  logic                          ahb_ready_in,
  output logic                          ahb_readyout_out,
  output logic                          ahb_resp_out,
  output logic [AHB_DATA_WIDTH-1:0]     ahb_rdata_out,
  output logic                          slv_req_out,
  output logic                          slv_write_out,
  output logic [AHB_ADDR_WIDTH-1:0]     slv_addr_out,
  output logic [AHB_DATA_WIDTH/8-1:0]   slv_strb_out,
  output logic [AHB_DATA_WIDTH-1:0]     slv_wdata_out,
  input  logic                          slv_ack_in,
  input  logic                          slv_err_in,
  input  logic [AHB_DATA_WIDTH-1:0]     slv_rdata_in
);

  localparam int unsigned StrbW = AHB_DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned CntW  = $clog2(SLV_WAIT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StDone,
    StErr1,
    StErr2
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [AHB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    write_q, write_d;
  logic [StrbW-1:0]        strb_q, strb_d;

  // Transfer decode
  logic [31:0]               xfer_bytes;
  logic [31:0]               xfer_bits;
  logic [AHB_ADDR_WIDTH-1:0] align_mask;
  logic [OffW-1:0]           lane_off;
  logic [StrbW-1:0]          strb_calc;
  logic                      xfer_bad;
  logic                      addr_phase;
  logic                      timeout_hit;

  // HBURST and HTRANS[0] carry no information here: every beat is addressed explicitly.
  logic unused_inputs;
  assign unused_inputs = ^{ahb_burst_in, ahb_trans_in[0]};

  assign xfer_bytes  = 32'd1 << ahb_size_in;
  assign xfer_bits   = xfer_bytes << 3;
  assign align_mask  = AHB_ADDR_WIDTH'(xfer_bytes - 32'd1);
  assign xfer_bad    = (xfer_bits > AHB_DATA_WIDTH) || (|(ahb_addr_in & align_mask));
  assign lane_off    = ahb_addr_in[OffW-1:0];
  // Only NONSEQ/SEQ with the bus ready open a data phase towards this slave.
  assign addr_phase  = ahb_sel_in & ahb_ready_in & ahb_trans_in[1];
  assign timeout_hit = (cnt_q == CntW'(SLV_WAIT_TIMEOUT - 1));

  // Byte lanes from addr offset up to offset + bytes - 1.
  always_comb begin
    strb_calc = '0;
    for (int i = 0; i < StrbW; i++) begin
      strb_calc[i] = (32'(i) >= 32'(lane_off)) && (32'(i) < 32'(lane_off) + xfer_bytes);
    end
  end

  // State register
  always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
    if (ahb_rst_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      strb_q  <= strb_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    write_d = write_q;
    strb_d  = strb_q;
    unique case (state_q)
      // Every state that drives HREADYOUT=1 may take a new address phase.
      StIdle, StDone, StErr2: begin
        if (addr_phase) begin
          if (xfer_bad) begin
            state_d = StErr1;
          end else begin
            state_d = StAccess;
            addr_d  = ahb_addr_in;
            write_d = ahb_write_in;
            strb_d  = strb_calc;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: begin
        if (slv_ack_in) begin
          state_d = slv_err_in ? StErr1 : StDone;
          cnt_d   = '0;
          rdata_d = write_q ? '0 : slv_rdata_in;
        end else if (timeout_hit) begin
          state_d = StErr1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    ahb_readyout_out = 1'b1;
    ahb_resp_out     = 1'b0;
    slv_req_out      = 1'b0;
    unique case (state_q)
      StAccess: begin
        ahb_readyout_out = 1'b0;
        slv_req_out      = 1'b1;
      end
      StErr1: begin
        ahb_readyout_out = 1'b0;
        ahb_resp_out     = 1'b1;
      end
      StErr2: begin
        ahb_resp_out = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign ahb_rdata_out = rdata_q;
  assign slv_write_out = write_q;
  assign slv_addr_out  = addr_q;
  assign slv_strb_out  = strb_q;
  // Safe as a pass-through: HREADYOUT=0 holds the master's HWDATA for the whole access.
  assign slv_wdata_out = ahb_wdata_in;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if (32-bit bus, wait timeout of 4 cycles).
module tb_ahb_slave_if;

  localparam int TMO = 4;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam int PH_OK = 0, PH_WAIT = 1, PH_E1 = 2, PH_E2 = 3;

  logic        clk, rst;
  logic        sel, write, hold_ready;
  logic [31:0] addr, wdata;
  logic [1:0]  trans;
  logic [2:0]  burst, size;
  wire         ready_in;
  logic        readyout, resp, req, s_write;
  logic [31:0] rdata, s_addr, s_wdata;
  logic [3:0]  s_strb;
  wire         ack;
  logic        resp_ack, spur_ack, err_val;
  logic [31:0] rd_val;
  int          ack_lat;

  int checks = 0;
  int failures = 0;

  // Measurements taken by the compare process
  int          req_hi_n = 0, rdy_lo_n = 0, resp_hi_n = 0;
  logic [3:0]  seen_strb;
  logic [31:0] seen_wdata;
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];

  // Reference model state: what the data phase currently looks like
  int          m_ph, m_waited;
  logic [31:0] m_addr, m_rdata;
  logic        m_write;
  logic [3:0]  m_strb;

  assign ready_in = readyout & ~hold_ready;
  assign ack      = resp_ack | spur_ack;

  ahb_slave_if #(
    .AHB_ADDR_WIDTH  (32),
    .AHB_DATA_WIDTH  (32),
    .SLV_WAIT_TIMEOUT(TMO)
  ) dut (
    .ahb_clk_in      (clk),
    .ahb_rst_in      (rst),
    .ahb_sel_in      (sel),
    .ahb_addr_in     (addr),
    .ahb_trans_in    (trans),
    .ahb_burst_in    (burst),
    .ahb_size_in     (size),
    .ahb_write_in    (write),
    .ahb_wdata_in    (wdata),
    .ahb_ready_in    (ready_in),
    .ahb_readyout_out(readyout),
    .ahb_resp_out    (resp),
    .ahb_rdata_out   (rdata),
    .slv_req_out     (req),
    .slv_write_out   (s_write),
    .slv_addr_out    (s_addr),
    .slv_strb_out    (s_strb),
    .slv_wdata_out   (s_wdata),
    .slv_ack_in      (ack),
    .slv_err_in      (err_val),
    .slv_rdata_in    (rd_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Backend: acknowledge on the ack_lat-th cycle of a request (0 = never).
  initial begin : responder
    int n;
    n = 0;
    resp_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (req) n++;
      else n = 0;
      resp_ack = req && (ack_lat != 0) && (n == ack_lat);
    end
  end

  // Model + per-cycle compare, sampled on the falling edge.
  initial begin : compare
    int nb;
    m_ph = PH_OK; m_waited = 0; m_addr = '0; m_rdata = '0; m_write = 1'b0; m_strb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ph = PH_OK; m_waited = 0; m_addr = '0; m_rdata = '0; m_write = 1'b0; m_strb = '0;
      end
      if (req) req_hi_n++;
      if (!readyout) rdy_lo_n++;
      if (resp) resp_hi_n++;
      if (req) begin
        seen_strb  = s_strb;
        seen_wdata = s_wdata;
      end
      if (req && ack) begin
        log_addr.push_back(s_addr);
        log_wdata.push_back(s_wdata);
      end
      chk("readyout", 64'(readyout), 64'(m_ph != PH_WAIT && m_ph != PH_E1));
      chk("resp", 64'(resp), 64'(m_ph == PH_E1 || m_ph == PH_E2));
      chk("req", 64'(req), 64'(m_ph == PH_WAIT));
      chk("slv_addr", 64'(s_addr), 64'(m_addr));
      chk("slv_write", 64'(s_write), 64'(m_write));
      chk("slv_strb", 64'(s_strb), 64'(m_strb));
      chk("rdata", 64'(rdata), 64'(m_rdata));
      chk("slv_wdata", 64'(s_wdata), 64'(wdata));
      if (!rst) begin
        case (m_ph)
          PH_WAIT: begin
            if (ack) begin
              m_rdata = m_write ? 32'd0 : rd_val;
              m_ph    = err_val ? PH_E1 : PH_OK;
            end else if (m_waited == TMO) begin
              m_ph = PH_E1;
            end else begin
              m_waited++;
            end
          end
          PH_E1: m_ph = PH_E2;
          default: begin
            if (sel && !hold_ready && trans[1]) begin
              nb = 1 << int'(size);
              if (nb * 8 > 32 || (int'(addr[7:0]) % nb) != 0) begin
                m_ph = PH_E1;
              end else begin
                m_addr   = addr;
                m_write  = write;
                m_strb   = 4'(((1 << nb) - 1) << int'(addr[1:0]));
                m_ph     = PH_WAIT;
                m_waited = 1;
              end
            end else begin
              m_ph = PH_OK;
            end
          end
        endcase
      end
    end
  end

  // Hold the bus until the slave is ready, so the driven address phase is taken.
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!ready_in) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got 0x0 expected 0x1 at %0t", $time);
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one address phase together with the previous beat's write data.
  task automatic beat(input logic s, input logic [1:0] tr, input logic [31:0] a,
                      input logic [2:0] sz, input logic wr, input logic [31:0] wd_prev);
    sel = s; trans = tr; addr = a; size = sz; write = wr; wdata = wd_prev;
    wait_ready();
  endtask

  int b_req, b_rdy, b_rsp, b_log;
  task automatic snap();
    b_req = req_hi_n; b_rdy = rdy_lo_n; b_rsp = resp_hi_n; b_log = log_addr.size();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    rst = 1'b1; sel = 0; addr = 0; trans = IDLE; burst = 0; size = 0; write = 0; wdata = 0;
    hold_ready = 0; err_val = 0; rd_val = 0; spur_ack = 0; ack_lat = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readyout", 64'(readyout), 64'd1);
    chk("rst_resp", 64'(resp), 64'd0);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_strb", 64'(s_strb), 64'd0);
    rst = 1'b0;

    // NONSEQ word write, ack on the second request cycle
    ack_lat = 2; snap();
    beat(1, NONSEQ, 32'h10, 3'd2, 1, 32'h0);
    beat(0, IDLE, 32'h0, 3'd0, 0, 32'hA5A55A5A);
    chk("t2_req_cycles", 64'(req_hi_n - b_req), 64'd2);
    chk("t2_wait_cycles", 64'(rdy_lo_n - b_rdy), 64'd2);
    chk("t2_resp_cycles", 64'(resp_hi_n - b_rsp), 64'd0);
    chk("t2_strb", 64'(seen_strb), 64'hF);
    chk("t2_wdata", 64'(seen_wdata), 64'hA5A55A5A);

    // NONSEQ halfword read, ack in the first cycle
    ack_lat = 1; rd_val = 32'h12345678; snap();
    beat(1, NONSEQ, 32'h4, 3'd1, 0, 32'h0);
    beat(0, IDLE, 32'h0, 3'd0, 0, 32'h0);
    chk("t3_strb", 64'(seen_strb), 64'h3);
    chk("t3_wait_cycles", 64'(rdy_lo_n - b_rdy), 64'd1);
    chk("t3_rdata", 64'(rdata), 64'h12345678);

    // Reset arriving in the middle of an access
    ack_lat = 0;
    beat(1, NONSEQ, 32'h0, 3'd2, 0, 32'h0);
    sel = 0; trans = IDLE;
    #2;
    chk("t1_req_before", 64'(req), 64'd1);
    rst = 1'b1;
    #1;
    chk("t1_req_in_rst", 64'(req), 64'd0);
    chk("t1_ready_in_rst", 64'(readyout), 64'd1);
    chk("t1_resp_in_rst", 64'(resp), 64'd0);
    chk("t1_rdata_in_rst", 64'(rdata), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Invalid transfers: misaligned word, doubleword on a 32-bit bus
    ack_lat = 1; snap();
    beat(1, NONSEQ, 32'h2, 3'd2, 0, 32'h0);
    beat(0, IDLE, 32'h0, 3'd0, 0, 32'h0);
    chk("t4a_req_cycles", 64'(req_hi_n - b_req), 64'd0);
    chk("t4a_wait_cycles", 64'(rdy_lo_n - b_rdy), 64'd1);
    chk("t4a_resp_cycles", 64'(resp_hi_n - b_rsp), 64'd2);
    snap();
    beat(1, NONSEQ, 32'h8, 3'd3, 1, 32'h0);
    beat(0, IDLE, 32'h0, 3'd0, 0, 32'h0);
    chk("t4b_req_cycles", 64'(req_hi_n - b_req), 64'd0);
    chk("t4b_resp_cycles", 64'(resp_hi_n - b_rsp), 64'd2);

    // Timeout: no ack ever
    ack_lat = 0; snap();
    beat(1, NONSEQ, 32'h30, 3'd2, 0, 32'h0);
    beat(0, IDLE, 32'h0, 3'd0, 0, 32'h0);
    chk("t5a_req_cycles", 64'(req_hi_n - b_req), 64'd4);
    chk("t5a_wait_cycles", 64'(rdy_lo_n - b_rdy), 64'd5);
    chk("t5a_resp_cycles", 64'(resp_hi_n - b_rsp), 64'd2);
    // Backend error on ack
    ack_lat = 1; err_val = 1; snap();
    beat(1, NONSEQ, 32'h34, 3'd2, 1, 32'h0);
    beat(0, IDLE, 32'h0, 3'd0, 0, 32'h11111111);
    err_val = 0;
    chk("t5b_req_cycles", 64'(req_hi_n - b_req), 64'd1);
    chk("t5b_wait_cycles", 64'(rdy_lo_n - b_rdy), 64'd2);
    chk("t5b_resp_cycles", 64'(resp_hi_n - b_rsp), 64'd2);

    // Unselected, and HREADY low: no access either way
    snap();
    beat(0, NONSEQ, 32'h50, 3'd2, 0, 32'h0);
    hold_ready = 1; sel = 1; trans = NONSEQ; addr = 32'h40;
    @(posedge clk);
    #1;
    hold_ready = 0; sel = 0; trans = IDLE;
    @(posedge clk);
    #1;
    chk("misc_req_cycles", 64'(req_hi_n - b_req), 64'd0);

    // Read, then a stray ack with no request must not touch HRDATA
    rd_val = 32'hCAFEF00D;
    beat(1, NONSEQ, 32'h8, 3'd2, 0, 32'h0);
    beat(0, IDLE, 32'h0, 3'd0, 0, 32'h0);
    chk("misc_rdata", 64'(rdata), 64'hCAFEF00D);
    rd_val = 32'hDEADBEEF; spur_ack = 1;
    @(posedge clk);
    #1;
    spur_ack = 0;
    @(posedge clk);
    #1;
    chk("misc_stray_ack", 64'(rdata), 64'hCAFEF00D);

    // INCR4 write with a BUSY after beat 2
    burst = 3'd3; ack_lat = 1; snap();
    beat(1, NONSEQ, 32'h20, 3'd2, 1, 32'h0);
    beat(1, SEQ,    32'h24, 3'd2, 1, 32'hD0D0D0D0);
    beat(1, BUSY,   32'h28, 3'd2, 1, 32'hD1D1D1D1);
    beat(1, SEQ,    32'h28, 3'd2, 1, 32'h0);
    beat(1, SEQ,    32'h2C, 3'd2, 1, 32'hD2D2D2D2);
    beat(0, IDLE,   32'h0,  3'd0, 0, 32'hD3D3D3D3);
    burst = 3'd0;
    chk("t6_beats", 64'(log_addr.size() - b_log), 64'd4);
    if (log_addr.size() - b_log == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t6_addr", 64'(log_addr[b_log + i]), 64'(32'h20 + 32'(4 * i)));
        chk("t6_wdata", 64'(log_wdata[b_log + i]), 64'(32'hD0D0D0D0 + 32'(i) * 32'h01010101));
      end
    end
    chk("t6_wait_cycles", 64'(rdy_lo_n - b_rdy), 64'd4);
    chk("t6_resp_cycles", 64'(resp_hi_n - b_rsp), 64'd0);
    chk("t6_rdata_cleared", 64'(rdata), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
